nv_rr_pipe_mux: RTL

NV_RR_PIPE_MUX -- requirements
Module: nv_rr_pipe_mux

---
 rtl/nv_rr_pipe_mux_if.sv | 25 ++
 rtl/nv_rr_pipe_mux.sv | 94 +++++++++
 2 files changed

// File: rtl/nv_rr_pipe_mux_if.sv
// Handshake bundle for nv_rr_pipe_mux: NUM request channels in, one registered beat out.
// The master drives requests and out_ready; the slave (the mux) drives grants and the output beat.
interface nv_rr_pipe_mux_if #(
    parameter int WIDTH = 32,
    parameter int NUM   = 4,
    parameter int SEL_W = $clog2(NUM)
);
    logic [NUM-1:0]       in_valid;
    logic [NUM-1:0]       in_ready;
    logic [NUM*WIDTH-1:0] in_pd;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_pd;
    logic [SEL_W-1:0]     out_sel;

    modport master (
        output in_valid, in_pd, out_ready,
        input  in_ready, out_valid, out_pd, out_sel
    );

    modport slave (
        input  in_valid, in_pd, out_ready,
        output in_ready, out_valid, out_pd, out_sel
    );
endinterface

// File: rtl/nv_rr_pipe_mux.sv
// N-to-1 arbitrating mux feeding a single-entry pipe register.
// MODE 0 rotates priority after each accepted beat; MODE 1 is fixed lowest-index priority.
module nv_rr_pipe_mux #(
    parameter int WIDTH = 32,
    parameter int NUM   = 4,
    parameter int MODE  = 0
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    nv_rr_pipe_mux_if.slave bus
);
    localparam int SEL_W = $clog2(NUM);

    logic             vld_p0;
    logic [WIDTH-1:0] pd_p0;
    logic [SEL_W-1:0] sel_p0;
    logic [SEL_W-1:0] ptr;

    logic             load_en;
    logic             xfer;
    logic [SEL_W:0]   gnt;
    logic             gnt_found;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W-1:0] gnt_start;
    logic [WIDTH-1:0] gnt_pd;

    // Walk the channels from 'start' upward with modulo-NUM wrap; the first requester wins.
    // Scanning from the far end lets the nearest hit overwrite, so no break is needed.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM-1:0] req,
                                               input logic [SEL_W-1:0] start);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] sidx;
        int               idx;
        res = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NUM) begin
                idx = idx - NUM;
            end
            sidx = idx[SEL_W-1:0];
            if (req[sidx]) begin
                res = {1'b1, sidx};
            end
        end
        return res;
    endfunction

    assign gnt_start = (MODE == 0) ? ptr : '0;
    assign gnt       = rr_pick(bus.in_valid, gnt_start);
    assign gnt_found = gnt[SEL_W];
    assign gnt_idx   = gnt[SEL_W-1:0];

    // A stalled full register blocks every grant; reset also blocks them.
    assign load_en = !vld_p0 || bus.out_ready;
    assign xfer    = load_en && gnt_found && nvdla_core_rstn;

    assign bus.in_ready = xfer ? (NUM'(1) << gnt_idx) : '0;

    always_comb begin
        gnt_pd = '0;
        for (int i = 0; i < NUM; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_pd = bus.in_pd[i*WIDTH +: WIDTH];
            end
        end
    end

    // Stage p0: output pipe register
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            vld_p0 <= 1'b0;
            pd_p0  <= '0;
            sel_p0 <= '0;
        end else if (xfer) begin
            vld_p0 <= 1'b1;
            pd_p0  <= gnt_pd;
            sel_p0 <= gnt_idx;
        end else if (bus.out_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ptr <= '0;
        end else if (xfer && (MODE == 0)) begin
            ptr <= (gnt_idx == SEL_W'(NUM - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign bus.out_valid = vld_p0;
    assign bus.out_pd    = pd_p0;
    assign bus.out_sel   = sel_p0;
endmodule
